// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage RISC-V core.
// Arbitrates between load-use stalls, EX branch redirects and data-memory wait.
// Owns a memory-wait timeout that aborts a hung access and produces a bus error pulse.
// Keeps three wrapping performance counters (stall, flush and wait cycles).
module pipeline_stall_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_en_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_we_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_we_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    // Timeout threshold widened by one bit so it can be compared with timer + 1.
    localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

    // Counter event index: 0 = load-use stall, 1 = branch flush, 2 = memory freeze.
    localparam int NUM_CNT = 3;

    state_t      state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [16:0] timer_count;
    logic        freeze;
    logic        timeout_hit;
    logic [NUM_CNT-1:0]       evt;
    logic [NUM_CNT*CNT_W-1:0] cnt_flat;

    assign freeze      = dmem_req_i & ~dmem_ready_i;
    // Frozen cycles so far including the current one.
    assign timer_count = {1'b0, timer_reg} + 17'd1;
    assign timeout_hit = (TIMEOUT != 0) && (timer_count == TIMEOUT_L);

    // Next-state, wait timer and Mealy enable/flush decode in priority order.
    always_comb begin
        state_next     = state_reg;
        timer_next     = 16'd0;
        evt            = '0;
        pc_we_o        = 1'b1;
        if_id_we_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_we_o     = 1'b1;
        id_ex_flush_o  = 1'b0;
        ex_mem_we_o    = 1'b1;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        bus_err_o      = 1'b0;

        if (rst_i) begin
            // Hold every stage and load bubbles everywhere.
            pc_we_o        = 1'b0;
            if_id_we_o     = 1'b0;
            id_ex_we_o     = 1'b0;
            ex_mem_we_o    = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
            state_next     = ST_RUN;
        end else if (state_reg == ST_ABORT) begin
            // Timeout recovery: squash the whole pipe, report the error once.
            bus_err_o      = 1'b1;
            pc_we_o        = 1'b0;
            if_id_we_o     = 1'b0;
            id_ex_we_o     = 1'b0;
            ex_mem_we_o    = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
            mem_wb_flush_o = 1'b1;
            state_next     = ST_RUN;
        end else if (freeze) begin
            // EX is held, so pending branch/stall requests survive the freeze.
            pc_we_o        = 1'b0;
            if_id_we_o     = 1'b0;
            id_ex_we_o     = 1'b0;
            ex_mem_we_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
            evt[2]         = 1'b1;
            timer_next     = (timer_reg == 16'hFFFF) ? timer_reg : timer_count[15:0];
            state_next     = timeout_hit ? ST_ABORT : ST_WAIT;
        end else begin
            state_next = ST_RUN;
            if (branch_taken_i) begin
                // Wrong-path IF and ID instructions are squashed; a stall is moot.
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                evt[1]        = 1'b1;
            end else if (stall_en_i) begin
                // Hold PC and IF/ID, insert a bubble into EX.
                pc_we_o       = 1'b0;
                if_id_we_o    = 1'b0;
                id_ex_flush_o = 1'b1;
                evt[0]        = 1'b1;
            end
        end
    end

    // State and wait-timer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
            timer_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // One wrapping counter per event; clear beats a same-cycle increment.
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        // Counter register for event gi.
        always_ff @(posedge clk_i) begin
            if (rst_i || cnt_clr_i) begin
                cnt_reg <= '0;
            end else if (evt[gi]) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
    end

    assign stall_cnt_o = cnt_flat[0*CNT_W +: CNT_W];
    assign flush_cnt_o = cnt_flat[1*CNT_W +: CNT_W];
    assign wait_cnt_o  = cnt_flat[2*CNT_W +: CNT_W];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed testbench for pipeline_stall_ctrl.
// u_dut uses TIMEOUT=4, CNT_W=4; u_dut1 shares the inputs and uses TIMEOUT=1.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst, stall_en, branch_taken, dmem_req, dmem_ready, cnt_clr;

    logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic ex_mem_we, ex_mem_flush, mem_wb_flush, bus_err;
    logic [3:0] stall_cnt, flush_cnt, wait_cnt;

    logic pc_we1, if_id_we1, if_id_flush1, id_ex_we1, id_ex_flush1;
    logic ex_mem_we1, ex_mem_flush1, mem_wb_flush1, bus_err1;
    logic [3:0] stall_cnt1, flush_cnt1, wait_cnt1;

    int n_vec  = 0;
    int n_miss = 0;

    // Control vector: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    //                  ex_mem_we, ex_mem_flush, mem_wb_flush, bus_err}
    localparam logic [8:0] C_RST    = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] C_ABORT  = 9'b0_0_1_0_1_0_1_1_1;
    localparam logic [8:0] C_FREEZE = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] C_BRANCH = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] C_STALL  = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] C_NORM   = 9'b1_1_0_1_0_1_0_0_0;

    wire [8:0] ctl  = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                       ex_mem_we, ex_mem_flush, mem_wb_flush, bus_err};
    wire [8:0] ctl1 = {pc_we1, if_id_we1, if_id_flush1, id_ex_we1, id_ex_flush1,
                       ex_mem_we1, ex_mem_flush1, mem_wb_flush1, bus_err1};

    pipeline_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en), .branch_taken_i(branch_taken),
        .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready), .cnt_clr_i(cnt_clr),
        .pc_we_o(pc_we), .if_id_we_o(if_id_we), .if_id_flush_o(if_id_flush),
        .id_ex_we_o(id_ex_we), .id_ex_flush_o(id_ex_flush), .ex_mem_we_o(ex_mem_we),
        .ex_mem_flush_o(ex_mem_flush), .mem_wb_flush_o(mem_wb_flush), .bus_err_o(bus_err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .wait_cnt_o(wait_cnt)
    );

    pipeline_stall_ctrl #(.TIMEOUT(1), .CNT_W(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en), .branch_taken_i(branch_taken),
        .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready), .cnt_clr_i(cnt_clr),
        .pc_we_o(pc_we1), .if_id_we_o(if_id_we1), .if_id_flush_o(if_id_flush1),
        .id_ex_we_o(id_ex_we1), .id_ex_flush_o(id_ex_flush1), .ex_mem_we_o(ex_mem_we1),
        .ex_mem_flush_o(ex_mem_flush1), .mem_wb_flush_o(mem_wb_flush1), .bus_err_o(bus_err1),
        .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1), .wait_cnt_o(wait_cnt1)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Drive one cycle of inputs, check the combinational control word mid-cycle.
    task automatic cyc(input string tag, input logic r, input logic st, input logic br,
                       input logic rq, input logic rd, input logic cl, input logic [8:0] exp);
        rst = r; stall_en = st; branch_taken = br;
        dmem_req = rq; dmem_ready = rd; cnt_clr = cl;
        @(negedge clk);
        chk(tag, {23'd0, ctl}, {23'd0, exp});
        @(posedge clk);
        #1;
    endtask

    // Check the registered counters of the main instance.
    task automatic cnts(input string tag, input logic [3:0] s, input logic [3:0] f,
                        input logic [3:0] w);
        chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, s});
        chk({tag, ".flush_cnt"}, {28'd0, flush_cnt}, {28'd0, f});
        chk({tag, ".wait_cnt"},  {28'd0, wait_cnt},  {28'd0, w});
    endtask

    initial begin
        // Reset
        cyc("rst0", 1, 0, 0, 0, 0, 0, C_RST);
        cyc("rst1", 1, 1, 1, 1, 0, 0, C_RST);
        cnts("after_rst", 0, 0, 0);
        cyc("idle", 0, 0, 0, 0, 0, 0, C_NORM);

        // Load-use stall
        cyc("loaduse", 0, 1, 0, 0, 0, 0, C_STALL);
        cnts("loaduse", 1, 0, 0);

        // Branch together with load-use (counters cleared first)
        cyc("clr_a", 0, 0, 0, 0, 0, 1, C_NORM);
        cyc("br_stall", 0, 1, 1, 0, 0, 0, C_BRANCH);
        cnts("br_stall", 0, 1, 0);

        // Memory wait with branch pending
        cyc("clr_b", 0, 0, 0, 0, 0, 1, C_NORM);
        for (int i = 0; i < 3; i++) cyc($sformatf("memwait%0d", i), 0, 0, 1, 1, 0, 0, C_FREEZE);
        cyc("memwait_rdy", 0, 0, 1, 1, 1, 0, C_BRANCH);
        cnts("memwait", 0, 1, 3);

        // Ready on the entry cycle: no freeze
        cyc("ready_entry", 0, 0, 0, 1, 1, 0, C_NORM);
        cyc("ready_entry_next", 0, 0, 0, 0, 0, 0, C_NORM);
        cnts("ready_entry", 0, 1, 3);

        // Reset during WAIT
        cyc("rstwait0", 0, 0, 0, 1, 0, 0, C_FREEZE);
        cyc("rstwait1", 0, 0, 0, 1, 0, 0, C_FREEZE);
        cyc("rstwait_rst", 1, 0, 0, 1, 0, 0, C_RST);
        cyc("rstwait_after", 0, 0, 0, 0, 0, 0, C_NORM);
        cnts("rstwait", 0, 0, 0);

        // Timeout: TIMEOUT=4 on u_dut, TIMEOUT=1 on u_dut1
        for (int k = 0; k < 10; k++) begin
            logic [8:0] e0, e1;
            e0 = (k == 4 || k == 9) ? C_ABORT : C_FREEZE;
            e1 = (k % 2 == 1) ? C_ABORT : C_FREEZE;
            rst = 0; stall_en = 0; branch_taken = 0; dmem_req = 1; dmem_ready = 0; cnt_clr = 0;
            @(negedge clk);
            chk($sformatf("timeout_c%0d", k), {23'd0, ctl}, {23'd0, e0});
            chk($sformatf("timeout1_c%0d", k), {23'd0, ctl1}, {23'd0, e1});
            @(posedge clk);
            #1;
        end
        cyc("timeout_end", 0, 0, 0, 0, 0, 0, C_NORM);
        cnts("timeout", 0, 0, 8);
        chk("timeout1.wait_cnt", {28'd0, wait_cnt1}, 32'd5);
        chk("timeout1.stall_cnt", {28'd0, stall_cnt1}, 32'd0);
        chk("timeout1.flush_cnt", {28'd0, flush_cnt1}, 32'd0);

        // Counter clear beats a same-cycle stall
        cyc("pre_clr_stall", 0, 1, 0, 0, 0, 0, C_STALL);
        cnts("pre_clr", 1, 0, 8);
        cyc("clr_stall", 0, 1, 0, 0, 0, 1, C_STALL);
        cnts("clr_stall", 0, 0, 0);

        // Counter wrap at CNT_W=4
        for (int i = 0; i < 15; i++) cyc($sformatf("wrap%0d", i), 0, 1, 0, 0, 0, 0, C_STALL);
        cnts("wrap15", 15, 0, 0);
        cyc("wrap15", 0, 1, 0, 0, 0, 0, C_STALL);
        cnts("wrap16", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
